onehot_seq_ctrl: RTL and testbench
==================================

# onehot_seq_ctrl

Registered controller around the four-state one-hot "101" sequence detector (states A, B, C, D; output high in D). It owns the state register and accepts serial bits over a valid/ready stream. Each match is reported as a held event handshake and counted. It also provides a configuration load path with one-hot legality checking and recovery. It sits between a serial bit source and a match consumer.

## Interface
- CNT_W, 16, width of the saturating match counter (≥2)
- clk  in  1  rising-edge clock; the only clock
- reset  in  1  synchronous, active-high reset
- en  in  1  enables bit acceptance
- clr  in  1  synchronous clear of match_count and err_onehot; state is unaffected
- cfg_load  in  1  forces the state register from cfg_state
- cfg_state  in  4  state to load; bit0=A, bit1=B, bit2=C, bit3=D
- in_valid  in  1  serial bit valid
- in_data  in  1  serial bit
- in_ready  out  1  bit accepted when in_valid & in_ready
- state  out  4  registered one-hot state
- out  out  1  state[3] (D)
- match_valid  out  1  match event pending
- match_ready  in  1  consumer accepts the match event
- match_count  out  CNT_W  saturating count of entries into D
- err_onehot  out  1  sticky flag: an illegal cfg_state was loaded

## Operation
- Accept = in_valid & in_ready.
- in_ready = en & ~cfg_load & ~(match_valid & ~match_ready). This is combinational. A pending, unconsumed match stalls input.
- Transitions apply on accept only; otherwise state holds.
  - A: 0→A, 1→B
  - B: 0→C, 1→B
  - C: 0→A, 1→D
  - D: 0→C, 1→B
- Matches overlap: in D, the bits 0 then 1 re-enter D.
- Entering D on an accepted bit (next state = D):
  - match_valid ← 1.
  - match_count increments, saturating at all-ones.
- match_valid clears on match_valid & match_ready. A simultaneous new entry into D is impossible, because in_ready requires match_ready in that case; the set wins if it ever coincides.
- cfg_load priority is reset > cfg_load > accept.
  - If cfg_state has exactly one bit set, state ← cfg_state.
  - Otherwise (0000 or two or more bits set), state ← 0001 and err_onehot ← 1.
  - A load never sets match_valid or increments the count, even when loading D. It does not cancel a pending match.
  - A load is honoured regardless of en.
- clr: match_count ← 0 and err_onehot ← 0.
  - clr beats a count increment in the same cycle.
  - An err_onehot set beats clr in the same cycle.
- en=0: in_ready=0 and state holds. Loads, clr and the match handshake still operate.

## Timing
- Reset values: state=0001, out=0, match_valid=0, match_count=0, err_onehot=0. in_ready is 0 during reset cycles.
- Latency is 1 cycle: a bit accepted at edge N is reflected in state/out/match_valid/match_count after edge N.
- out and match_valid rise in the same cycle on a match. out falls on the next accepted bit; match_valid falls on its handshake.
- A cfg_load at edge N updates state after edge N. err_onehot is visible in the same cycle.
- Reset mid-operation (any state, pending match, any load) returns everything to reset values at the next edge. The bit presented during reset is not accepted.

## Test plan
- Overlap: match_ready=1, en=1, bits 1,0,1,0,1 each valid. Required:
  - out=1 after the 3rd and 5th accepts.
  - State sequence B,C,D,C,D.
  - match_count=2; match_valid pulses two single cycles.
- Backpressure: match_ready=0 after the first match, then offer bit 0. Required:
  - in_ready=0, state stays D, match_valid stays 1.
  - Raise match_ready: accept occurs, state→C, match_valid→0.
- Illegal load: cfg_load with cfg_state=0110 while in_valid=1. Required:
  - Bit not accepted, state=0001, err_onehot=1, count unchanged.
  - Then clr gives err_onehot=0.
- Legal load of D: cfg_state=1000. Required: state=1000, out=1, match_valid=0, count unchanged. Next bit 1 gives state B.
- Saturation with CNT_W=2: four matches. Required:
  - match_count 1,2,3,3.
  - clr in the same cycle as the 5th match gives count 0.
- Reset in D with a match pending: required state=0001, match_valid=0, match_count=0, err_onehot=0. With en=0 afterwards, in_ready=0 and state holds.

Source files
------------

// File: rtl/onehot_seq_ctrl_if.sv
// Stream bundle for onehot_seq_ctrl: the serial bit input and the match event output.
// Handshake: a transfer happens on a rising clk edge where valid & ready are both 1.
interface onehot_seq_ctrl_if;
    logic in_valid;
    logic in_data;
    logic in_ready;
    logic match_valid;
    logic match_ready;

    modport master (
        output in_valid,
        output in_data,
        output match_ready,
        input  in_ready,
        input  match_valid
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  match_ready,
        output in_ready,
        output match_valid
    );
endinterface

// File: rtl/onehot_seq_ctrl.sv
// Registered one-hot "101" detector (A,B,C,D; out high in D) with stream input,
// held match event handshake, saturating match counter and checked state load.
module onehot_seq_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic             i_cfg_load,
    input  logic [3:0]       i_cfg_state,
    onehot_seq_ctrl_if.slave bus,
    output logic [3:0]       o_state,
    output logic             o_out,
    output logic [CNT_W-1:0] o_match_count,
    output logic             o_err_onehot
);
    localparam logic [3:0] ST_A = 4'b0001;
    localparam logic [3:0] ST_B = 4'b0010;
    localparam logic [3:0] ST_C = 4'b0100;
    localparam logic [3:0] ST_D = 4'b1000;

    logic [3:0]       r_state;
    logic             r_match_valid;
    logic [CNT_W-1:0] r_match_count;
    logic             r_err_onehot;

    logic             w_in_ready;
    logic             w_accept;
    logic [3:0]       w_next_state;
    logic             w_enter_d;
    logic             w_match_hs;
    logic             w_cfg_legal;
    logic             w_cnt_sat;

    // A pending match that the consumer is not taking this cycle stalls input,
    // so a second entry into D can never overwrite an unconsumed event.
    assign w_in_ready = i_en & ~i_reset & ~i_cfg_load & ~(r_match_valid & ~bus.match_ready);
    assign w_accept   = bus.in_valid & w_in_ready;
    assign w_match_hs = r_match_valid & bus.match_ready;
    assign w_cnt_sat  = &r_match_count;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign w_cfg_legal = (i_cfg_state != 4'b0000) &&
                         ((i_cfg_state & (i_cfg_state - 4'd1)) == 4'b0000);

    always_comb begin
        w_next_state = ST_A;
        case (r_state)
            ST_A:    w_next_state = bus.in_data ? ST_B : ST_A;
            ST_B:    w_next_state = bus.in_data ? ST_B : ST_C;
            ST_C:    w_next_state = bus.in_data ? ST_D : ST_A;
            ST_D:    w_next_state = bus.in_data ? ST_B : ST_C;
            default: w_next_state = ST_A;
        endcase
    end

    assign w_enter_d = w_accept & (w_next_state == ST_D);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_A;
        end else if (i_cfg_load) begin
            r_state <= w_cfg_legal ? i_cfg_state : ST_A;
        end else if (w_accept) begin
            r_state <= w_next_state;
        end
    end

    // Set has priority over the handshake clear should the two ever coincide.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_match_valid <= 1'b0;
        end else if (w_enter_d) begin
            r_match_valid <= 1'b1;
        end else if (w_match_hs) begin
            r_match_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_match_count <= '0;
        end else if (i_clr) begin
            r_match_count <= '0;
        end else if (w_enter_d && !w_cnt_sat) begin
            r_match_count <= r_match_count + 1'b1;
        end
    end

    // A new illegal load outranks clr so the error is never silently lost.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_err_onehot <= 1'b0;
        end else if (i_cfg_load && !w_cfg_legal) begin
            r_err_onehot <= 1'b1;
        end else if (i_clr) begin
            r_err_onehot <= 1'b0;
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.match_valid = r_match_valid;
    assign o_state         = r_state;
    assign o_out           = r_state[3];
    assign o_match_count   = r_match_count;
    assign o_err_onehot    = r_err_onehot;
endmodule

// File: tb/tb_onehot_seq_ctrl.sv
// Directed bench for onehot_seq_ctrl (CNT_W=2 so saturation is reachable).
// Observed vector w_obs = {state, out, match_valid, match_count, err_onehot}.
module tb_onehot_seq_ctrl;
    localparam int CNT_W = 2;

    logic             clk;
    logic             reset;
    logic             en;
    logic             clr;
    logic             cfg_load;
    logic [3:0]       cfg_state;
    logic [3:0]       state;
    logic             out;
    logic [CNT_W-1:0] match_count;
    logic             err_onehot;

    int checks;
    int failures;

    onehot_seq_ctrl_if bus ();

    onehot_seq_ctrl #(.CNT_W(CNT_W)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_en          (en),
        .i_clr         (clr),
        .i_cfg_load    (cfg_load),
        .i_cfg_state   (cfg_state),
        .bus           (bus),
        .o_state       (state),
        .o_out         (out),
        .o_match_count (match_count),
        .o_err_onehot  (err_onehot)
    );

    wire [8:0] w_obs = {state, out, bus.match_valid, match_count, err_onehot};

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks: inputs change 1ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; clr = 1'b0; cfg_load = 1'b0; cfg_state = 4'b0000;
        bus.in_valid = 1'b1; bus.in_data = 1'b1; bus.match_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready);
        end
        tick(); tick();
        checks++;
        if (w_obs !== {4'b0001, 1'b0, 1'b0, 2'd0, 1'b0}) begin
            failures++; $display("FAIL reset_values got=%b exp=%b", w_obs, {4'b0001, 5'b0});
        end
        reset = 1'b0; bus.in_valid = 1'b0;
        tick();
        checks++;
        if (w_obs !== {4'b0001, 1'b0, 1'b0, 2'd0, 1'b0}) begin
            failures++; $display("FAIL reset_release got=%b exp=%b", w_obs, {4'b0001, 5'b0});
        end
    endtask

    task automatic test_overlap();
        logic       bits  [5];
        logic [8:0] exp_v [5];
        bits = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_v = '{{4'b0010, 1'b0, 1'b0, 2'd0, 1'b0},
                  {4'b0100, 1'b0, 1'b0, 2'd0, 1'b0},
                  {4'b1000, 1'b1, 1'b1, 2'd1, 1'b0},
                  {4'b0100, 1'b0, 1'b0, 2'd1, 1'b0},
                  {4'b1000, 1'b1, 1'b1, 2'd2, 1'b0}};
        bus.match_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_bit(bits[i]);
            checks++;
            if (w_obs !== exp_v[i]) begin
                failures++; $display("FAIL overlap_step%0d got=%b exp=%b", i, w_obs, exp_v[i]);
            end
        end
        tick();
        checks++;
        if (w_obs !== {4'b1000, 1'b1, 1'b0, 2'd2, 1'b0}) begin
            failures++; $display("FAIL overlap_mv_clear got=%b exp=%b", w_obs, {4'b1000, 1'b1, 1'b0, 2'd2, 1'b0});
        end
    endtask

    task automatic test_backpressure();
        cfg_load = 1'b1; cfg_state = 4'b0001; clr = 1'b1;
        tick();
        cfg_load = 1'b0; clr = 1'b0;
        bus.match_ready = 1'b0;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        checks++;
        if (w_obs !== {4'b1000, 1'b1, 1'b1, 2'd1, 1'b0}) begin
            failures++; $display("FAIL bp_match got=%b exp=%b", w_obs, {4'b1000, 1'b1, 1'b1, 2'd1, 1'b0});
        end
        bus.in_valid = 1'b1; bus.in_data = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++; $display("FAIL bp_stall_ready got=%b exp=0", bus.in_ready);
        end
        tick();
        checks++;
        if (w_obs !== {4'b1000, 1'b1, 1'b1, 2'd1, 1'b0}) begin
            failures++; $display("FAIL bp_hold got=%b exp=%b", w_obs, {4'b1000, 1'b1, 1'b1, 2'd1, 1'b0});
        end
        bus.match_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL bp_release_ready got=%b exp=1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (w_obs !== {4'b0100, 1'b0, 1'b0, 2'd1, 1'b0}) begin
            failures++; $display("FAIL bp_accept got=%b exp=%b", w_obs, {4'b0100, 1'b0, 1'b0, 2'd1, 1'b0});
        end
    endtask

    task automatic test_illegal_load();
        cfg_load = 1'b1; cfg_state = 4'b0110;
        bus.in_valid = 1'b1; bus.in_data = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++; $display("FAIL ill_ready got=%b exp=0", bus.in_ready);
        end
        tick();
        cfg_load = 1'b0; bus.in_valid = 1'b0;
        checks++;
        if (w_obs !== {4'b0001, 1'b0, 1'b0, 2'd1, 1'b1}) begin
            failures++; $display("FAIL ill_load got=%b exp=%b", w_obs, {4'b0001, 1'b0, 1'b0, 2'd1, 1'b1});
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (w_obs !== {4'b0001, 1'b0, 1'b0, 2'd0, 1'b0}) begin
            failures++; $display("FAIL ill_clr got=%b exp=%b", w_obs, {4'b0001, 5'b0});
        end
        clr = 1'b1; cfg_load = 1'b1; cfg_state = 4'b0000;
        tick();
        clr = 1'b0; cfg_load = 1'b0;
        checks++;
        if (w_obs !== {4'b0001, 1'b0, 1'b0, 2'd0, 1'b1}) begin
            failures++; $display("FAIL ill_err_beats_clr got=%b exp=%b", w_obs, {4'b0001, 1'b0, 1'b0, 2'd0, 1'b1});
        end
    endtask

    task automatic test_load_d();
        cfg_load = 1'b1; cfg_state = 4'b1000;
        tick();
        cfg_load = 1'b0;
        checks++;
        if (w_obs !== {4'b1000, 1'b1, 1'b0, 2'd0, 1'b1}) begin
            failures++; $display("FAIL load_d got=%b exp=%b", w_obs, {4'b1000, 1'b1, 1'b0, 2'd0, 1'b1});
        end
        send_bit(1'b1);
        checks++;
        if (w_obs !== {4'b0010, 1'b0, 1'b0, 2'd0, 1'b1}) begin
            failures++; $display("FAIL load_d_next got=%b exp=%b", w_obs, {4'b0010, 1'b0, 1'b0, 2'd0, 1'b1});
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt [4];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3};
        clr = 1'b1; cfg_load = 1'b1; cfg_state = 4'b0001;
        tick();
        clr = 1'b0; cfg_load = 1'b0;
        send_bit(1'b1);
        for (int i = 0; i < 4; i++) begin
            send_bit(1'b0); send_bit(1'b1);
            checks++;
            if (w_obs !== {4'b1000, 1'b1, 1'b1, exp_cnt[i], 1'b0}) begin
                failures++; $display("FAIL sat_match%0d got=%b exp=%b", i, w_obs, {4'b1000, 1'b1, 1'b1, exp_cnt[i], 1'b0});
            end
        end
        send_bit(1'b0);
        clr = 1'b1;
        send_bit(1'b1);
        clr = 1'b0;
        checks++;
        if (w_obs !== {4'b1000, 1'b1, 1'b1, 2'd0, 1'b0}) begin
            failures++; $display("FAIL sat_clr_beats_inc got=%b exp=%b", w_obs, {4'b1000, 1'b1, 1'b1, 2'd0, 1'b0});
        end
    endtask

    task automatic test_reset_mid();
        send_bit(1'b0);
        cfg_load = 1'b1; cfg_state = 4'b1111;
        tick();
        cfg_load = 1'b0;
        bus.match_ready = 1'b0;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        checks++;
        if (w_obs !== {4'b1000, 1'b1, 1'b1, 2'd1, 1'b1}) begin
            failures++; $display("FAIL rm_setup got=%b exp=%b", w_obs, {4'b1000, 1'b1, 1'b1, 2'd1, 1'b1});
        end
        reset = 1'b1; bus.in_valid = 1'b1; bus.in_data = 1'b0; bus.match_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++; $display("FAIL rm_ready_in_reset got=%b exp=0", bus.in_ready);
        end
        tick();
        checks++;
        if (w_obs !== {4'b0001, 1'b0, 1'b0, 2'd0, 1'b0}) begin
            failures++; $display("FAIL rm_reset got=%b exp=%b", w_obs, {4'b0001, 5'b0});
        end
        reset = 1'b0; en = 1'b0; bus.in_data = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++; $display("FAIL rm_en0_ready got=%b exp=0", bus.in_ready);
        end
        tick();
        checks++;
        if (w_obs !== {4'b0001, 1'b0, 1'b0, 2'd0, 1'b0}) begin
            failures++; $display("FAIL rm_en0_hold got=%b exp=%b", w_obs, {4'b0001, 5'b0});
        end
        cfg_load = 1'b1; cfg_state = 4'b0100;
        tick();
        cfg_load = 1'b0; bus.in_valid = 1'b0;
        checks++;
        if (w_obs !== {4'b0100, 1'b0, 1'b0, 2'd0, 1'b0}) begin
            failures++; $display("FAIL rm_en0_load got=%b exp=%b", w_obs, {4'b0100, 5'b0});
        end
    endtask

    // Sequence and final report
    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_overlap();
        test_backpressure();
        test_illegal_load();
        test_load_d();
        test_saturation();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
